// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and widths for the MEM-stage SRAM controller.
// Both SRAM halves of a pipeline word are moved through these states.
package sram_mem_ctrl_pkg;

    localparam int SRAM_ADDR_LEN = 18;
    localparam int SRAM_DATA_LEN = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } sram_state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter for SRAM half-word accesses.
// Reloads on phase entry and flags the last held cycle.
module sram_wait_counter
    import sram_mem_ctrl_pkg::*;
#(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(CYCLES - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller: each 32-bit load/store becomes two
// half-word accesses to an external asynchronous SRAM.
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter int WORD_LEN    = 32,
    parameter int SRAM_ADDR_W = SRAM_ADDR_LEN,
    parameter int SRAM_DATA_W = SRAM_DATA_LEN,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_R_EN,
    input  logic                   MEM_W_EN,
    input  logic [WORD_LEN-1:0]    ALU_res,
    input  logic [WORD_LEN-1:0]    ST_value,
    output logic [WORD_LEN-1:0]    dataMem_out,
    output logic                   ready,
    output logic                   freeze,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    localparam int  WIDX_W = SRAM_ADDR_W - 1;
    localparam int  DW     = SRAM_DATA_W;
    // With a single-cycle phase there is no spare hold cycle.
    localparam bit  HOLD   = (WAIT_CYCLES > 1);

    sram_state_t           state;
    sram_state_t           state_n;
    logic                  load;
    logic                  last;
    logic                  req;
    logic                  rd;
    logic                  wr;
    logic                  hi;
    logic [WIDX_W-1:0]     widx_n;
    logic [WIDX_W-1:0]     widx_q;
    logic [WORD_LEN-1:0]   st_q;
    logic [WORD_LEN-1:0]   data_q;

    sram_wait_counter #(
        .CYCLES (WAIT_CYCLES)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .last (last)
    );

    assign req    = MEM_R_EN | MEM_W_EN;
    assign widx_n = WIDX_W'((ALU_res - WORD_LEN'(BASE_ADDR)) >> 2);

    always_comb begin
        state_n = state;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (MEM_W_EN) begin
                    state_n = WR_LO;
                    load    = 1'b1;
                end else if (MEM_R_EN) begin
                    state_n = RD_LO;
                    load    = 1'b1;
                end
            end
            RD_LO: begin
                if (last) begin
                    state_n = RD_HI;
                    load    = 1'b1;
                end
            end
            RD_HI: if (last) state_n = DONE;
            WR_LO: begin
                if (last) begin
                    state_n = WR_HI;
                    load    = 1'b1;
                end
            end
            WR_HI: if (last) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            widx_q <= '0;
            st_q   <= '0;
            data_q <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req) begin
                widx_q <= widx_n;
                st_q   <= ST_value;
            end
            if (state == RD_LO && last) data_q[DW-1:0] <= SRAM_DQ;
            if (state == RD_HI && last) data_q[WORD_LEN-1:DW] <= SRAM_DQ;
        end
    end

    assign rd = (state == RD_LO) | (state == RD_HI);
    assign wr = (state == WR_LO) | (state == WR_HI);
    assign hi = (state == RD_HI) | (state == WR_HI);

    assign ready  = (state == DONE) | (state == IDLE & ~req);
    assign freeze = req & ~ready;

    assign SRAM_ADDR = (rd | wr) ? {widx_q, hi} : '0;
    assign SRAM_OE_N = ~rd;
    assign SRAM_WE_N = ~wr | (last & HOLD);
    assign SRAM_DQ   = wr ? (hi ? st_q[WORD_LEN-1:DW] : st_q[DW-1:0])
                          : {DW{1'bz}};

    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign dataMem_out = data_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: two instances (2-cycle and 1-cycle waits)
// against SRAM arrays and a word-level reference memory.
module tb_sram_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  r_en;
    logic [1:0]  w_en;
    logic [31:0] alu [2];
    logic [31:0] stv [2];

    wire  [31:0] dout0, dout1;
    wire         rdy0, rdy1, frz0, frz1;
    wire  [17:0] ad0, ad1;
    wire  [15:0] dq0, dq1;
    wire         we0, we1, oe0, oe1;
    wire         ce0, ub0, lb0, ce1, ub1, lb1;

    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];
    logic [31:0] ref_w [int unsigned];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sram_mem_ctrl #(.WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en[0]), .MEM_W_EN(w_en[0]),
        .ALU_res(alu[0]), .ST_value(stv[0]), .dataMem_out(dout0),
        .ready(rdy0), .freeze(frz0), .SRAM_ADDR(ad0), .SRAM_DQ(dq0),
        .SRAM_WE_N(we0), .SRAM_OE_N(oe0), .SRAM_CE_N(ce0),
        .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
    );

    sram_mem_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en[1]), .MEM_W_EN(w_en[1]),
        .ALU_res(alu[1]), .ST_value(stv[1]), .dataMem_out(dout1),
        .ready(rdy1), .freeze(frz1), .SRAM_ADDR(ad1), .SRAM_DQ(dq1),
        .SRAM_WE_N(we1), .SRAM_OE_N(oe1), .SRAM_CE_N(ce1),
        .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
    );

    // Async read; cells follow the bus while WE_N is low and keep it on release.
    assign dq0 = (!oe0 && we0) ? mem0[ad0] : 16'hzzzz;
    assign dq1 = (!oe1 && we1) ? mem1[ad1] : 16'hzzzz;
    always @(negedge clk) if (!we0) mem0[ad0] <= dq0;
    always @(negedge clk) if (!we1) mem1[ad1] <= dq1;

    function automatic logic rdy(input int d);
        return (d == 0) ? rdy0 : rdy1;
    endfunction
    function automatic logic frz(input int d);
        return (d == 0) ? frz0 : frz1;
    endfunction
    function automatic logic oen(input int d);
        return (d == 0) ? oe0 : oe1;
    endfunction
    function automatic logic wen(input int d);
        return (d == 0) ? we0 : we1;
    endfunction
    function automatic logic [15:0] dqv(input int d);
        return (d == 0) ? dq0 : dq1;
    endfunction
    function automatic logic [31:0] dout(input int d);
        return (d == 0) ? dout0 : dout1;
    endfunction

    function automatic int unsigned key(input int d, input logic [31:0] a);
        return (d << 17) | (((a - 32'd1024) >> 2) & 32'h1FFFF);
    endfunction

    function automatic logic [31:0] ref_rd(input int unsigned k);
        return ref_w.exists(k) ? ref_w[k] : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic access(input int d, input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] s,
                          input string tag);
        int          wc;
        int          lat;
        bit          is_rd;
        logic [31:0] prev;
        wc    = (d == 0) ? 2 : 1;
        is_rd = r && !w;
        prev  = dout(d);
        @(posedge clk); #1;
        r_en[d] = r; w_en[d] = w; alu[d] = a; stv[d] = s;
        @(negedge clk);
        chk({tag, "/c0_freeze"}, 32'(frz(d)), 32'd1);
        chk({tag, "/c0_oe_n"}, 32'(oen(d)), 32'd1);
        lat = 0;
        while (!rdy(d) && lat < 20) begin
            @(posedge clk); @(negedge clk);
            lat++;
            if (!rdy(d)) begin
                chk({tag, "/busy_freeze"}, 32'(frz(d)), 32'd1);
                chk({tag, "/busy_oe_n"}, 32'(oen(d)), is_rd ? 32'd0 : 32'd1);
            end
        end
        chk({tag, "/latency"}, 32'(lat), 32'(2 * wc + 1));
        chk({tag, "/done_freeze"}, 32'(frz(d)), 32'd0);
        if (w) begin
            ref_w[key(d, a)] = s;
            chk({tag, "/dout_kept"}, dout(d), prev);
        end else begin
            chk({tag, "/rdata"}, dout(d), ref_rd(key(d, a)));
        end
        @(posedge clk); #1;
        r_en[d] = 1'b0; w_en[d] = 1'b0;
    endtask

    task automatic idle_chk(input int d, input string tag);
        chk({tag, "/ready"}, 32'(rdy(d)), 32'd1);
        chk({tag, "/freeze"}, 32'(frz(d)), 32'd0);
        chk({tag, "/we_n"}, 32'(wen(d)), 32'd1);
        chk({tag, "/oe_n"}, 32'(oen(d)), 32'd1);
        chk({tag, "/dq"}, {16'h0, dqv(d)}, {16'h0, 16'hzzzz});
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] s;
        int          op;
        rst = 1'b0;
        r_en = 2'b00; w_en = 2'b00;
        alu[0] = '0; alu[1] = '0; stv[0] = '0; stv[1] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);

        idle_chk(0, "rst0");
        idle_chk(1, "rst1");
        chk("rst/dout0", dout0, 32'h0);
        chk("rst/addr0", {14'h0, ad0}, 32'h0);
        chk("rst/ties", {29'h0, ce0, ub0, lb0}, 32'h0);

        access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, "st1028");
        chk("st1028/m2", {16'h0, mem0[2]}, 32'h0000BEEF);
        chk("st1028/m3", {16'h0, mem0[3]}, 32'h0000DEAD);
        access(0, 1'b1, 1'b0, 32'd1028, 32'h0, "ld1028");
        chk("ld1028/value", dout0, 32'hDEADBEEF);

        access(0, 1'b1, 1'b1, 32'd1032, 32'h12345678, "rw1032");
        chk("rw1032/m4", {16'h0, mem0[4]}, 32'h00005678);
        chk("rw1032/m5", {16'h0, mem0[5]}, 32'h00001234);

        for (int i = 0; i < 16; i++) begin
            access(0, 1'b0, 1'b1, 32'd1024 + 32'(4 * i) + 32'($urandom_range(0, 3)),
                   $urandom, "fill");
        end

        @(posedge clk); #1;
        w_en[0] = 1'b1; alu[0] = 32'd1040; stv[0] = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1; w_en[0] = 1'b0;
        @(negedge clk);
        idle_chk(0, "abort");
        chk("abort/dout0", dout0, 32'h0);
        s = ref_rd(key(0, 32'd1040));
        ref_w[key(0, 32'd1040)] = {s[31:16], 16'hF00D};
        access(0, 1'b1, 1'b0, 32'd1040, 32'h0, "abort_ld");

        access(0, 1'b0, 1'b1, 32'd0, 32'hA5A55A5A, "wrap_st");
        access(0, 1'b1, 1'b0, 32'd3, 32'h0, "wrap_ld");

        for (int i = 0; i < 24; i++) begin
            a  = 32'd1024 + 32'($urandom_range(0, 63));
            s  = $urandom;
            op = $urandom_range(0, 2);
            access(0, op != 1, op != 0, a, s, "rand");
        end

        access(1, 1'b0, 1'b1, 32'd1024, 32'h0BADF00D, "w1_st1024");
        access(1, 1'b0, 1'b1, 32'd1025, 32'h13579BDF, "w1_st1025");
        access(1, 1'b1, 1'b0, 32'd1024, 32'h0, "w1_ld1024");
        chk("w1_ld1024/value", dout1, 32'h13579BDF);
        access(1, 1'b1, 1'b0, 32'd1025, 32'h0, "w1_ld1025");
        for (int i = 0; i < 8; i++) begin
            op = $urandom_range(0, 1);
            access(1, op == 0, op == 1, 32'd1024 + 32'($urandom_range(0, 15)),
                   $urandom, "w1_rand");
        end

        @(negedge clk);
        idle_chk(1, "end1");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
